// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter for the 8-bit computer.
//
// It counts 0..MAX_COUNT and then wraps to 0. One count step happens every
// PRESCALE enabled clock cycles. The block also provides a synchronous jump
// load, a single-step mode, and halt/stop inputs.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   start     enter RUNNING (level or pulse)
//   stop      enter STOPPED (level or pulse)
//   hlt       halt from the control sequencer; acts like stop
//   step      single-step request, accepted only while STOPPED
//   load      synchronous jump strobe; count takes load_val
//   load_val  jump target
//   count     current program address (registered)
//   tick      combinational; high in the cycle before count advances
//   wrapped   registered one-cycle pulse after a MAX_COUNT -> 0 increment
//   running   registered; high in RUNNING or STEPPING
module pc_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 7,
  parameter int unsigned PRESCALE  = 65536,
  parameter int unsigned PS_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hlt,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrapped,
  output logic             running
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam logic [PS_W-1:0]  PsLast = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    StStopped,
    StRunning,
    StStepping
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             running_q;
  logic             halt_req;

  assign halt_req = stop | hlt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StStopped;
      ps_q      <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      running_q <= (state_d != StStopped);
    end
  end

  // Next-state logic. Priority is stop/hlt, then start, then step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStopped: begin
        if (halt_req) begin
          state_d = StStopped;
        end else if (start) begin
          state_d = StRunning;
        end else if (step) begin
          state_d = StStepping;
        end
      end
      StRunning: begin
        if (halt_req) begin
          state_d = StStopped;
        end
      end
      StStepping: begin
        // A single step ends at the edge where its one tick fires.
        if (halt_req || tick) begin
          state_d = StStopped;
        end
      end
      default: state_d = StStopped;
    endcase
  end

  // Tick is suppressed by a coincident stop/hlt, so that increment never happens.
  always_comb begin
    tick = !reset && (state_q != StStopped) && (ps_q == PsLast) && !halt_req;
  end

  // Prescaler. It is held at 0 while stopped and restarts from 0 on every entry
  // into an active state. That restart gives a fixed PRESCALE latency to the first tick.
  always_comb begin
    ps_d = ps_q;
    if (state_d == StStopped || state_q == StStopped) begin
      ps_d = '0;
    end else if (ps_q == PsLast) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // Count update. A load overrides any tick that happens in the same cycle.
  // A value above MAX_COUNT wraps to 0 on its next tick.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q >= MaxVal)) begin
      count_d   = '0;
      wrapped_d = 1'b1;
    end else if (tick) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Outputs
  always_comb begin
    count   = count_q;
    wrapped = wrapped_q;
    running = running_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
// The driver applies inputs 1 time unit after each rising edge. It then pushes the
// expected outputs for that cycle, including the combinational tick, into a queue.
// The monitor pops one entry at every falling edge and compares it with the DUT.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       hlt;
  logic       step;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count1, count2;
  logic       tick1, tick2;
  logic       wrapped1, wrapped2;
  logic       running1, running2;

  int checks;
  int failures;

  typedef struct {
    bit         sel;
    logic [3:0] count;
    logic       tick;
    logic       wrapped;
    logic       running;
    string      name;
  } exp_t;

  exp_t sb[$];

  // Control vector bits: {reset, start, stop, hlt, step, load}
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] R = 6'b100000;
  localparam logic [5:0] S = 6'b010000;
  localparam logic [5:0] P = 6'b001000;
  localparam logic [5:0] H = 6'b000100;
  localparam logic [5:0] T = 6'b000010;
  localparam logic [5:0] L = 6'b000001;

  pc_sequencer #(
    .WIDTH    (4),
    .MAX_COUNT(7),
    .PRESCALE (4),
    .PS_W     (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .hlt     (hlt),
    .step    (step),
    .load    (load),
    .load_val(load_val),
    .count   (count1),
    .tick    (tick1),
    .wrapped (wrapped1),
    .running (running1)
  );

  pc_sequencer #(
    .WIDTH    (4),
    .MAX_COUNT(7),
    .PRESCALE (1),
    .PS_W     (1)
  ) dut_p1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .hlt     (hlt),
    .step    (step),
    .load    (load),
    .load_val(load_val),
    .count   (count2),
    .tick    (tick2),
    .wrapped (wrapped2),
    .running (running2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic drive(input logic [5:0] ctl, input logic [3:0] lv, input bit sel,
                       input logic [3:0] ec, input logic et, input logic ew,
                       input logic er, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    {reset, start, stop, hlt, step, load} = ctl;
    load_val  = lv;
    e.sel     = sel;
    e.count   = ec;
    e.tick    = et;
    e.wrapped = ew;
    e.running = er;
    e.name    = nm;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    logic [6:0] req;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.sel ? {count2, tick2, wrapped2, running2} : {count1, tick1, wrapped1, running1};
      req = {e.count, e.tick, e.wrapped, e.running};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL %s: got count=%0d tick=%b wrapped=%b running=%b, want count=%0d tick=%b wrapped=%b running=%b",
                 e.name, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    hlt      = 1'b0;
    step     = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;

    drive(R, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
    drive(S, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "idle_start");

    // Start-up latency, tick one cycle in four, and a wrap repeated twice
    for (int c = 0; c < 8; c++)
      for (int p = 0; p < 4; p++)
        drive(N, 4'd0, 1'b0, 4'(c), p == 3, 1'b0, 1'b1, "run1");
    for (int c = 0; c < 8; c++)
      for (int p = 0; p < 4; p++)
        drive(N, 4'd0, 1'b0, 4'(c), p == 3, (c == 0) && (p == 0), 1'b1, "run2");
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 4; p++)
        drive(N, 4'd0, 1'b0, 4'(c), p == 3, (c == 0) && (p == 0), 1'b1, "run3");

    // Load in a tick cycle, then an out-of-range load
    drive(N, 4'd0,  1'b0, 4'd2,  1'b0, 1'b0, 1'b1, "pre_load0");
    drive(N, 4'd0,  1'b0, 4'd2,  1'b0, 1'b0, 1'b1, "pre_load1");
    drive(N, 4'd0,  1'b0, 4'd2,  1'b0, 1'b0, 1'b1, "pre_load2");
    drive(L, 4'd2,  1'b0, 4'd2,  1'b1, 1'b0, 1'b1, "load_tick");
    drive(L, 4'd12, 1'b0, 4'd2,  1'b0, 1'b0, 1'b1, "load_no_inc");
    drive(N, 4'd0,  1'b0, 4'd12, 1'b0, 1'b0, 1'b1, "load_big1");
    drive(N, 4'd0,  1'b0, 4'd12, 1'b0, 1'b0, 1'b1, "load_big2");
    drive(N, 4'd0,  1'b0, 4'd12, 1'b1, 1'b0, 1'b1, "load_big_tick");
    drive(N, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b1, "big_wrap");

    // hlt in a tick cycle, then start and stop together
    drive(N,     4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "pre_hlt1");
    drive(N,     4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "pre_hlt2");
    drive(H,     4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "hlt_tick");
    drive(N,     4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "hlt_stopped");
    drive(S | P, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "start_stop");
    drive(N,     4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "start_stop_held");

    // Single step from count 3; a second step while stepping is ignored
    drive(L, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "load3");
    drive(T, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "step_req");
    drive(T, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, "step_ignored");
    drive(N, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, "step_ps1");
    drive(N, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, "step_ps2");
    drive(N, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, "step_tick");
    drive(N, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "step_done");
    drive(N, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "step_hold1");
    drive(N, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "step_hold2");

    // Asynchronous reset in the middle of a prescale period, with count at 5
    drive(L, 4'd5, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "load5");
    drive(S, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, "start5");
    drive(N, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, "run5_ps0");
    drive(N, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, "run5_ps1");
    drive(R, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset_mid");

    // PRESCALE=1 instance: one increment every clock cycle while running
    drive(S, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "p1_idle");
    for (int j = 0; j < 9; j++)
      drive(N, 4'd0, 1'b1, 4'(j % 8), 1'b1, j == 8, 1'b1, "p1_run");
    drive(P, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, "p1_stop");
    drive(N, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, "p1_stopped");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
